// File: rtl/gf_div_if.sv
`default_nettype none
// ============================================================================
// Module      : gf_div_if
// Description : Operation handshake and operand/result bundle for the
//               bit-serial GF(2) polynomial divider. Uses the same level
//               handshake (op_enable / op_finish) as the sequential GF
//               multiplier, so one controller can drive either unit.
// Ports       : op_enable         - level request from the controller
//               in_div_a          - 2N-bit dividend polynomial
//               in_div_b          - N-bit divisor polynomial
//               out_div_quotient  - 2N-bit registered quotient
//               out_div_remainder - N-bit registered remainder
//               out_div_by_zero   - last completed operation had divisor 0
//               op_finish         - high while the divider sits in DONE
// Revision    : 1.0 - initial release
// ============================================================================
interface gf_div_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      op_enable;
   logic [2*DATA_WIDTH-1:0]   in_div_a;
   logic [DATA_WIDTH-1:0]     in_div_b;
   logic [2*DATA_WIDTH-1:0]   out_div_quotient;
   logic [DATA_WIDTH-1:0]     out_div_remainder;
   logic                      out_div_by_zero;
   logic                      op_finish;

   // Controller side
   modport master (
      output op_enable,
      output in_div_a,
      output in_div_b,
      input  out_div_quotient,
      input  out_div_remainder,
      input  out_div_by_zero,
      input  op_finish
   );

   // Divider side
   modport slave (
      input  op_enable,
      input  in_div_a,
      input  in_div_b,
      output out_div_quotient,
      output out_div_remainder,
      output out_div_by_zero,
      output op_finish
   );
endinterface : gf_div_if
`default_nettype wire

// File: rtl/gf_div.sv
`default_nettype none
// ============================================================================
// Module      : gf_div
// Description : Sequential bit-serial GF(2) polynomial (carry-less) long
//               divider. Divides a 2N-bit dividend by an N-bit divisor,
//               producing quotient and remainder such that
//               dividend = quotient (x) divisor ^ remainder.
//               One dividend bit is consumed per clock, MSB first.
// Ports       : clk  - clock, all state updates on the rising edge
//               rst  - asynchronous active-high reset
//               bus  - gf_div_if.slave: op_enable/in_div_a/in_div_b in,
//                      out_div_quotient/out_div_remainder/out_div_by_zero/
//                      op_finish out
// Revision    : 1.0 - initial release
// ============================================================================
module gf_div #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic  clk,
   input  wire logic  rst,
   gf_div_if.slave    bus
);

   localparam int C_DEG_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int C_CNT_W = $clog2(2*DATA_WIDTH);
   localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(2*DATA_WIDTH-1);
   localparam logic [C_CNT_W-1:0] C_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t                    r_state;
   logic [2*DATA_WIDTH-1:0]   r_a;        // dividend, shifted left each step
   logic [DATA_WIDTH-1:0]     r_b;        // captured divisor
   logic [C_DEG_W-1:0]        r_deg;      // degree of captured divisor
   logic [DATA_WIDTH-1:0]     r_rem;      // working remainder
   logic [2*DATA_WIDTH-1:0]   r_q;        // quotient shift register
   logic [C_CNT_W-1:0]        r_cnt;      // steps remaining minus one
   logic [2*DATA_WIDTH-1:0]   r_quot;
   logic [DATA_WIDTH-1:0]     r_rem_out;
   logic                      r_dbz;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   state_t                    w_state_next;
   logic [C_DEG_W-1:0]        w_deg;
   logic                      w_b_zero;
   logic [DATA_WIDTH-1:0]     w_t;
   logic                      w_qbit;
   logic [DATA_WIDTH-1:0]     w_rem_next;
   logic [2*DATA_WIDTH-1:0]   w_q_next;
   logic                      w_last;

   // Priority encoder: the highest set bit wins because later iterations
   // overwrite earlier ones. A zero divisor yields 0 but is handled
   // separately via w_b_zero.
   always_comb begin
      w_deg = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bus.in_div_b[i]) begin
            w_deg = C_DEG_W'(i);
         end
      end
   end

   assign w_b_zero = (bus.in_div_b == '0);

   // One long-division step. The working remainder always has degree below
   // deg(divisor) <= N-1, so dropping its top bit during the shift loses
   // nothing.
   assign w_t        = {r_rem[DATA_WIDTH-2:0], r_a[2*DATA_WIDTH-1]};
   assign w_qbit     = w_t[r_deg];
   assign w_rem_next = w_qbit ? (w_t ^ r_b) : w_t;
   assign w_q_next   = {r_q[2*DATA_WIDTH-2:0], w_qbit};
   assign w_last     = (r_cnt == C_CNT_ZERO);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic. Dropping op_enable in RUN aborts, and takes
   // priority over completing on the final step.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.op_enable) begin
               w_state_next = w_b_zero ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (!bus.op_enable) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.op_enable) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_deg     <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_quot    <= '0;
         r_rem_out <= '0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.op_enable) begin
                  r_a   <= bus.in_div_a;
                  r_b   <= bus.in_div_b;
                  r_deg <= w_deg;
                  r_rem <= '0;
                  r_q   <= '0;
                  r_cnt <= C_CNT_INIT;
                  // Divide-by-zero completes on the capture edge itself.
                  if (w_b_zero) begin
                     r_quot    <= '0;
                     r_rem_out <= '0;
                     r_dbz     <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (bus.op_enable) begin
                  r_a   <= {r_a[2*DATA_WIDTH-2:0], 1'b0};
                  r_rem <= w_rem_next;
                  r_q   <= w_q_next;
                  if (w_last) begin
                     r_quot    <= w_q_next;
                     r_rem_out <= w_rem_next;
                     r_dbz     <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: begin
               // DONE: results held; nothing to update.
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.out_div_quotient  = r_quot;
   assign bus.out_div_remainder = r_rem_out;
   assign bus.out_div_by_zero   = r_dbz;
   assign bus.op_finish         = (r_state == S_DONE);

endmodule : gf_div
`default_nettype wire
